program_loader: RTL and testbench

Boot-time loader that sits directly upstream of the pipelined CPU. It receives a framed byte stream over a valid/ready link and assembles big-endian 16-bit instruction words. It writes those words into instruction memory at consecutive halfword addresses. It holds the CPU out of execution (`cpu_run` = 0) until a complete frame with a correct checksum has been written.

---
 rtl/program_loader.sv | 110 +++++++++++
 tb/tb_program_loader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot loader: parses A5/count/data/checksum frames from a byte stream, writes
// big-endian 16-bit words to instruction memory and releases the CPU on success.
module program_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [15:0] imem_wdata,
  output logic        cpu_run,
  output logic        load_error,
  output logic [15:0] words_loaded
);

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam logic [16:0] MAX_W     = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK, RUN, ERROR
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] count_q;
  logic [15:0] word_idx;
  logic [7:0]  hi_byte;
  logic [7:0]  sum;
  logic        accept;
  logic [15:0] count_rx;

  // Held low during reset so nothing upstream sees a ready loader before it can accept.
  assign rx_ready   = reset && (state != RUN) && (state != ERROR);
  assign accept     = rx_valid && rx_ready;
  assign cpu_run    = (state == RUN);
  assign load_error = (state == ERROR);
  assign count_rx   = {count_q[15:8], rx_data};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        IDLE:    if (rx_data == SYNC_BYTE) state_nxt = CNT_HI;
        CNT_HI:  state_nxt = CNT_LO;
        CNT_LO:  begin
          if (count_rx == 16'd0 || {1'b0, count_rx} > MAX_W) state_nxt = ERROR;
          else                                                 state_nxt = DATA_HI;
        end
        DATA_HI: state_nxt = DATA_LO;
        DATA_LO: begin
          if (word_idx + 16'd1 == count_q) state_nxt = CHECK;
          else                             state_nxt = DATA_HI;
        end
        CHECK:   begin
          if (rx_data == sum) state_nxt = RUN;
          else                state_nxt = ERROR;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Datapath: count/sum/word assembly, write strobe registered one cycle after the low byte.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q      <= '0;
      word_idx     <= '0;
      hi_byte      <= '0;
      sum          <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      if (accept) begin
        case (state)
          CNT_HI:  count_q[15:8] <= rx_data;
          CNT_LO:  begin
            count_q[7:0] <= rx_data;
            word_idx     <= '0;
            sum          <= '0;
          end
          DATA_HI: begin
            hi_byte <= rx_data;
            sum     <= sum + rx_data;
          end
          DATA_LO: begin
            sum          <= sum + rx_data;
            imem_we      <= 1'b1;
            imem_addr    <= BASE_ADDR + {word_idx[14:0], 1'b0};
            imem_wdata   <= {hi_byte, rx_data};
            word_idx     <= word_idx + 16'd1;
            words_loaded <= words_loaded + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: expected writes go into a scoreboard queue
// as bytes are driven and are popped when the loader strobes imem_we.
module tb_program_loader;

  logic        clock;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_run;
  logic        load_error;
  logic [15:0] words_loaded;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb[$];
  logic        prev_we;

  typedef logic [7:0] bq_t[$];

  program_loader dut (
    .clock       (clock),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .cpu_run     (cpu_run),
    .load_error  (load_error),
    .words_loaded(words_loaded)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every strobe must match the oldest expected write,
  // and a strobe never lasts two cycles.
  always @(negedge clock) begin
    if (!reset) begin
      prev_we = 1'b0;
    end else begin
      if (imem_we) begin
        check("we_single_cycle", {31'd0, prev_we}, 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_write", {imem_addr, imem_wdata}, 32'hxxxxxxxx);
        end else begin
          check("write_addr_data", {imem_addr, imem_wdata}, sb.pop_front());
        end
      end
      prev_we = imem_we;
    end
  end

  // Entered and left at 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clock); #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (!rx_ready && t < 50) begin
      @(posedge clock); #1;
      t++;
    end
    if (!rx_ready) check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
    @(posedge clock); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] cnt, input bq_t data, input logic [7:0] csum,
                            input int max_gap, input bit count_ok, input int stop_after);
    logic [7:0] hi;
    int         k;
    send_byte(8'hA5, (max_gap > 0) ? $urandom_range(max_gap) : 0);
    send_byte(cnt[15:8], (max_gap > 0) ? $urandom_range(max_gap) : 0);
    send_byte(cnt[7:0], (max_gap > 0) ? $urandom_range(max_gap) : 0);
    if (!count_ok) return;
    hi = 8'h00;
    k  = 0;
    for (int i = 0; i < data.size(); i++) begin
      if (i == stop_after) return;
      if (i % 2 == 0) begin
        hi = data[i];
      end else begin
        sb.push_back({16'h0000 + 16'(2 * k), hi, data[i]});
      end
      send_byte(data[i], (max_gap > 0) ? $urandom_range(max_gap) : 0);
      if (i % 2 == 1) begin
        k++;
        check("we_latency", {31'd0, imem_we}, 32'd1);
        check("words_loaded_step", {16'd0, words_loaded}, k);
      end
    end
    check("no_run_before_csum", {31'd0, cpu_run}, 32'd0);
    send_byte(csum, (max_gap > 0) ? $urandom_range(max_gap) : 0);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check("rst_rx_ready_low", {31'd0, rx_ready}, 32'd0);
    check("rst_imem_we", {31'd0, imem_we}, 32'd0);
    check("rst_words_loaded", {16'd0, words_loaded}, 32'd0);
    check("rst_cpu_run", {31'd0, cpu_run}, 32'd0);
    check("rst_load_error", {31'd0, load_error}, 32'd0);
    sb.delete();
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check("rel_rx_ready", {31'd0, rx_ready}, 32'd1);
    check("rel_imem_addr", {16'd0, imem_addr}, 32'd0);
    check("rel_imem_wdata", {16'd0, imem_wdata}, 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic check_done(input string tag, input bit run, input bit err, input logic [15:0] wl);
    check({tag, "_cpu_run"}, {31'd0, cpu_run}, {31'd0, run});
    check({tag, "_load_error"}, {31'd0, load_error}, {31'd0, err});
    check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    check({tag, "_words_loaded"}, {16'd0, words_loaded}, {16'd0, wl});
    repeat (3) @(posedge clock);
    #1;
    check({tag, "_sb_empty"}, sb.size(), 32'd0);
    check({tag, "_held"}, {30'd0, cpu_run, load_error}, {30'd0, run, err});
  endtask

  initial begin
    bq_t good;
    good     = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    prev_we  = 1'b0;
    @(posedge clock); #1;

    // Reset values and a back-to-back good load.
    do_reset();
    send_frame(16'd2, good, 8'hBE, 0, 1'b1, -1);
    check_done("good", 1'b1, 1'b0, 16'd2);

    // Garbage first, then the same frame with random valid gaps.
    do_reset();
    send_byte(8'h00, 1);
    send_byte(8'hFF, 0);
    send_byte(8'h5A, 2);
    check("garbage_rx_ready", {31'd0, rx_ready}, 32'd1);
    check("garbage_words", {16'd0, words_loaded}, 32'd0);
    send_frame(16'd2, good, 8'hBE, 4, 1'b1, -1);
    check_done("gappy", 1'b1, 1'b0, 16'd2);

    // Bad checksum: both words still written, then error.
    do_reset();
    send_frame(16'd2, good, 8'hBF, 0, 1'b1, -1);
    check_done("badsum", 1'b0, 1'b1, 16'd2);

    // Count above MAX_WORDS and zero count.
    do_reset();
    send_frame(16'h0101, good, 8'h00, 0, 1'b0, -1);
    check_done("cnt_big", 1'b0, 1'b1, 16'd0);
    do_reset();
    send_frame(16'h0000, good, 8'h00, 0, 1'b0, -1);
    check_done("cnt_zero", 1'b0, 1'b1, 16'd0);

    // Reset after the third data byte, then a clean frame from BASE_ADDR.
    do_reset();
    send_frame(16'd2, good, 8'hBE, 0, 1'b1, 3);
    check("partial_words", {16'd0, words_loaded}, 32'd1);
    do_reset();
    send_frame(16'd2, good, 8'hBE, 0, 1'b1, -1);
    check_done("after_rst", 1'b1, 1'b0, 16'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
